datapath_jogo: RTL and testbench

//  Datapath for the memory game: executes the command lines (r1,r2,e1..e4,sel) issued by the game

---
 rtl/datapath_jogo.sv | 185 ++++++++++++++++++
 tb/tb_datapath_jogo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_jogo.sv
// Memory-game datapath: symbol table, LED playback, key capture/compare, timeout and round count.
// Build option SEQ_LFSR_EN: symbol table filled from a 16-bit LFSR seeded by sw instead of (3*i+sw) mod 4.
module datapath_jogo #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int ROUNDS        = 16,
    parameter int TIMEOUT_TICKS = 5
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       r1,
    input  logic       r2,
    input  logic       e1,
    input  logic       e2,
    input  logic       e3,
    input  logic       e4,
    input  logic       sel,
    input  logic [7:0] sw,
    input  logic [3:0] key,
    output logic       end_fpga,
    output logic       end_user,
    output logic       end_time,
    output logic       win,
    output logic       match,
    output logic [3:0] leds,
    output logic [4:0] score
);
    localparam int RW = $clog2(ROUNDS + 1);
    localparam int UW = $clog2(ROUNDS + 2);
    localparam int IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);

    logic          act_e1, act_e2, act_e3, act_e4;
    logic [TW-1:0] tcnt;
    logic          run, tick;
    logic [3:0]    k1, k2, k3;
    logic          press, key_ok;
    logic [1:0]    key_sym;
    logic [1:0]    sym [ROUNDS];
    logic [IW-1:0] wi;
    logic [1:0]    gen_sym;
    logic [UW-1:0] idx, uidx;
    logic [RW-1:0] rnd;
    logic [OW-1:0] tocnt;
    logic          play_on, err, e4_q;

    // Clears dominate, then one enable acts per cycle in order e1 > e3 > e2 > e4.
    assign act_e1 = e1 && !r1 && !r2;
    assign act_e3 = e3 && !e1 && !r1 && !r2;
    assign act_e2 = e2 && !e3 && !e1 && !r1 && !r2;
    assign act_e4 = e4 && !e2 && !e3 && !e1 && !r1 && !r2;

    // Playback counts from the cycle after the first symbol appears, so each entry gets a full tick.
    assign run  = act_e2 || (act_e3 && play_on);
    assign tick = run && (tcnt == TW'(TICK_DIV - 1));

    assign press = |(k2 & ~k3);

    always_comb begin
        key_ok  = 1'b1;
        key_sym = 2'd0;
        case (k2)
            4'b0001: key_sym = 2'd0;
            4'b0010: key_sym = 2'd1;
            4'b0100: key_sym = 2'd2;
            4'b1000: key_sym = 2'd3;
            default: key_ok  = 1'b0;
        endcase
    end

`ifdef SEQ_LFSR_EN
    logic [15:0] lfsr, lfsr_cur;
    logic        e1_q;

    assign lfsr_cur = (act_e1 && !e1_q) ? {sw, 8'hA5} : lfsr;
    assign gen_sym  = lfsr_cur[1:0];

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            lfsr <= '0;
            e1_q <= 1'b0;
        end else if (r1) begin
            lfsr <= '0;
            e1_q <= 1'b0;
        end else begin
            e1_q <= act_e1;
            if (act_e1)
                lfsr <= {lfsr_cur[14:0], lfsr_cur[15] ^ lfsr_cur[13] ^ lfsr_cur[12] ^ lfsr_cur[10]};
        end
    end
`else
    logic unused_sw;
    assign unused_sw = ^sw[7:2];
    assign gen_sym   = 2'(3 * int'(wi) + int'(sw[1:0]));
`endif

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROUNDS; i++) sym[i] <= 2'b00;
            wi <= '0;
        end else if (r1) begin
            for (int i = 0; i < ROUNDS; i++) sym[i] <= 2'b00;
            wi <= '0;
        end else if (act_e1) begin
            sym[wi] <= gen_sym;
            wi      <= (wi == IW'(ROUNDS - 1)) ? '0 : wi + IW'(1);
        end
    end

    // Keys are stored inverted so a cleared synchronizer reads as "nothing pressed".
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            k1 <= '0;
            k2 <= '0;
            k3 <= '0;
        end else begin
            k1 <= ~key;
            k2 <= k1;
            k3 <= k2;
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            tcnt <= '0; idx <= '0; uidx <= '0; tocnt <= '0; rnd <= '0;
            play_on <= 1'b0; err <= 1'b0; e4_q <= 1'b0;
            end_fpga <= 1'b0; end_user <= 1'b0; end_time <= 1'b0;
        end else if (r1) begin
            tcnt <= '0; idx <= '0; uidx <= '0; tocnt <= '0; rnd <= '0;
            play_on <= 1'b0; err <= 1'b0; e4_q <= 1'b0;
            end_fpga <= 1'b0; end_user <= 1'b0; end_time <= 1'b0;
        end else if (r2) begin
            tcnt <= '0; idx <= '0; uidx <= '0; tocnt <= '0;
            play_on <= 1'b0; err <= 1'b0; e4_q <= e4;
            end_fpga <= 1'b0; end_user <= 1'b0; end_time <= 1'b0;
        end else begin
            e4_q <= e4;
            if (run)
                tcnt <= tick ? '0 : tcnt + TW'(1);

            if (act_e3) begin
                if (!play_on)
                    play_on <= 1'b1;
                else if (tick && !end_fpga) begin
                    if (idx == UW'(rnd)) end_fpga <= 1'b1;
                    else                 idx      <= idx + UW'(1);
                end
            end

            if (act_e2 && !end_user) begin
                // A press in the terminal-tick cycle wins over the timeout.
                if (press) begin
                    tocnt <= '0;
                    if (key_ok && key_sym == sym[uidx[IW-1:0]]) begin
                        uidx <= uidx + UW'(1);
                        if (uidx == UW'(rnd)) end_user <= 1'b1;
                    end else begin
                        err      <= 1'b1;
                        end_user <= 1'b1;
                    end
                end else if (tick && !end_time) begin
                    tocnt <= tocnt + OW'(1);
                    if (tocnt == OW'(TIMEOUT_TICKS - 1)) end_time <= 1'b1;
                end
            end

            if (act_e4 && !e4_q && match && rnd != RW'(ROUNDS))
                rnd <= rnd + RW'(1);
        end
    end

    assign match = !err && (uidx == UW'(rnd) + UW'(1));
    assign win   = (rnd == RW'(ROUNDS));
    assign score = 5'(rnd);

    always_comb begin
        leds = 4'b0000;
        if (sel)
            leds = win ? 4'b1111 : 4'b0000;
        else if (act_e3 && play_on && !end_fpga)
            leds = 4'b0001 << sym[idx[IW-1:0]];
        else if (act_e2)
            leds = k2;
    end
endmodule

// File: tb/tb_datapath_jogo.sv
// Directed bench for datapath_jogo with TICK_DIV=4, ROUNDS=4, TIMEOUT_TICKS=3.
`timescale 1ns/1ps
module tb_datapath_jogo;
    localparam int TICK_DIV      = 4;
    localparam int ROUNDS        = 4;
    localparam int TIMEOUT_TICKS = 3;

    logic       clock_50 = 1'b0;
    logic       reset = 1'b0;
    logic       r1 = 1'b0, r2 = 1'b0, e1 = 1'b0, e2 = 1'b0, e3 = 1'b0, e4 = 1'b0, sel = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [3:0] key = 4'hF;
    logic       end_fpga, end_user, end_time, win, match;
    logic [3:0] leds;
    logic [4:0] score;

    datapath_jogo #(
        .TICK_DIV(TICK_DIV), .ROUNDS(ROUNDS), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clock_50(clock_50), .reset(reset), .r1(r1), .r2(r2),
        .e1(e1), .e2(e2), .e3(e3), .e4(e4), .sel(sel), .sw(sw), .key(key),
        .end_fpga(end_fpga), .end_user(end_user), .end_time(end_time),
        .win(win), .match(match), .leds(leds), .score(score)
    );

    always #5 clock_50 = ~clock_50;

    logic [13:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [13:0] obs;
    assign obs = {end_fpga, end_user, end_time, win, match, leds, score};

    function automatic logic [13:0] mk(input logic ef, input logic eu, input logic et,
                                       input logic w, input logic m,
                                       input logic [3:0] l, input logic [4:0] s);
        return {ef, eu, et, w, m, l, s};
    endfunction

    function automatic logic [1:0] sym_of(input int i, input logic [1:0] s);
        return 2'((3 * i + int'(s)) % 4);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock_50);
        #1;
    endtask

    task automatic expect_v(input logic [13:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag);
        logic [13:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got %b but no expected entry queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: got %b required %b {ef,eu,et,win,match,leds,score}", tag, obs, e);
            end
        end
    endtask

    task automatic press(input logic [3:0] mask);
        key = ~mask;
        tick(3);
        key = 4'hF;
        tick(3);
    endtask

    task automatic clear_round();
        r2 = 1'b1;
        tick(1);
        r2 = 1'b0;
    endtask

    initial begin
        // reset state
        expect_v(14'd0);
        tick(2);
        check("reset");
        reset = 1'b1;
        tick(1);

        // build table with sw=0 -> 0,3,2,1 and play round 0
        r1 = 1'b1; tick(1); r1 = 1'b0;
        sw = 8'h00; e1 = 1'b1; tick(4); e1 = 1'b0;
        clear_round();
        for (int i = 0; i < 4; i++) expect_v(mk(0, 0, 0, 0, 0, 4'b0001, 5'd0));
        expect_v(mk(1, 0, 0, 0, 0, 4'b0000, 5'd0));
        e3 = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(1); check("play_r0"); end
        e3 = 1'b0;

        // enter round 0 and advance
        clear_round();
        e2 = 1'b1;
        expect_v(mk(0, 1, 0, 0, 1, 4'b0000, 5'd0));
        press(4'b0001);
        check("entry_r0");
        e2 = 1'b0; e4 = 1'b1;
        expect_v(mk(0, 1, 0, 0, 0, 4'b0000, 5'd1));
        tick(1); check("inc_r0");
        e4 = 1'b0;

        // round 1: playback 0 then 3, then correct entry
        clear_round();
        for (int i = 0; i < 4; i++) expect_v(mk(0, 0, 0, 0, 0, 4'b0001, 5'd1));
        for (int i = 0; i < 4; i++) expect_v(mk(0, 0, 0, 0, 0, 4'b1000, 5'd1));
        expect_v(mk(1, 0, 0, 0, 0, 4'b0000, 5'd1));
        e3 = 1'b1;
        for (int i = 0; i < 9; i++) begin tick(1); check("play_r1"); end
        e3 = 1'b0;
        clear_round();
        e2 = 1'b1;
        expect_v(mk(0, 1, 0, 0, 1, 4'b0000, 5'd1));
        press(4'b0001);
        press(4'b1000);
        check("entry_r1");
        e2 = 1'b0; e4 = 1'b1;
        expect_v(mk(0, 1, 0, 0, 1, 4'b0000, 5'd1));
        #1; check("match_first_e4");
        expect_v(mk(0, 1, 0, 0, 0, 4'b0000, 5'd2));
        tick(1); check("inc_r1");
        expect_v(mk(0, 1, 0, 0, 0, 4'b0000, 5'd2));
        tick(1); check("e4_held");
        e4 = 1'b0;

        // wrong key ends entry with error, score unchanged
        clear_round();
        e2 = 1'b1;
        expect_v(mk(0, 1, 0, 0, 0, 4'b0000, 5'd2));
        press(4'b0010);
        check("wrong_sym");
        e2 = 1'b0; e4 = 1'b1;
        expect_v(mk(0, 1, 0, 0, 0, 4'b0000, 5'd2));
        #1; check("e4_nomatch");
        expect_v(mk(0, 1, 0, 0, 0, 4'b0000, 5'd2));
        tick(1); check("no_inc");
        e4 = 1'b0;

        // two keys at once is a wrong symbol even if one is correct
        clear_round();
        e2 = 1'b1;
        key = 4'b1100;
        expect_v(mk(0, 1, 0, 0, 0, 4'b0011, 5'd2));
        tick(3); check("multi_key");
        key = 4'hF; tick(3);
        e2 = 1'b0;

        // timeout after 3 ticks of silence
        clear_round();
        e2 = 1'b1;
        expect_v(mk(0, 0, 0, 0, 0, 4'b0000, 5'd2));
        tick(11); check("before_timeout");
        expect_v(mk(0, 0, 1, 0, 0, 4'b0000, 5'd2));
        tick(1); check("timeout");
        e2 = 1'b0;

        // press landing on the terminal tick suppresses the timeout
        clear_round();
        e2 = 1'b1;
        tick(9);
        key = 4'b1110;
        expect_v(mk(0, 0, 0, 0, 0, 4'b0001, 5'd2));
        tick(3); check("press_on_terminal");
        expect_v(mk(0, 0, 0, 0, 0, 4'b0001, 5'd2));
        tick(4); check("after_terminal");
        key = 4'hF; tick(1);
        e2 = 1'b0;

        // global clear, new table with sw=2, four correct rounds
        r1 = 1'b1; tick(1); r1 = 1'b0;
        expect_v(14'd0);
        check("r1_clear");
        sw = 8'h02; e1 = 1'b1; tick(4); e1 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            clear_round();
            e2 = 1'b1;
            expect_v(mk(0, 1, 0, 0, 1, 4'b0000, 5'(r)));
            for (int i = 0; i <= r; i++) press(4'b0001 << sym_of(i, 2'd2));
            check("entry_round");
            e2 = 1'b0; e4 = 1'b1;
            expect_v(mk(0, 1, 0, (r == 3), 0, 4'b0000, 5'(r + 1)));
            tick(1); check("score_round");
            e4 = 1'b0;
        end
        sel = 1'b1;
        expect_v(mk(0, 1, 0, 1, 0, 4'b1111, 5'd4));
        #1; check("sel_win");
        sel = 1'b0;
        expect_v(mk(0, 1, 0, 1, 0, 4'b0000, 5'd4));
        #1; check("sel_off");
        r1 = 1'b1; tick(1); r1 = 1'b0;
        expect_v(14'd0);
        check("r1_after_win");

        // asynchronous reset in the middle of playback
        sw = 8'h01; e1 = 1'b1; tick(4); e1 = 1'b0;
        clear_round();
        e3 = 1'b1;
        expect_v(mk(0, 0, 0, 0, 0, 4'b0001 << sym_of(0, 2'd1), 5'd0));
        tick(2); check("play_before_reset");
        reset = 1'b0;
        expect_v(14'd0);
        #2; check("async_reset");
        tick(1);
        e3 = 1'b0; reset = 1'b1;
        tick(1);
        e3 = 1'b1;
        expect_v(mk(0, 0, 0, 0, 0, 4'b0001, 5'd0));
        tick(1); check("table_cleared");
        e3 = 1'b0;

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
